// File: rtl/clint_pkg.sv
// Shared constants and register bundle for the core-local interruptor.
// The optional RTC divider is enabled by defining CLINT_RTC_DIV_EN.
package clint_pkg;

  localparam logic [15:0] clint_msip      = 16'h0000;
  localparam logic [15:0] clint_mtimecmp  = 16'h4000;
  localparam logic [15:0] clint_mtimecmph = 16'h4004;
  localparam logic [15:0] clint_mtime     = 16'hBFF8;
  localparam logic [15:0] clint_mtimeh    = 16'hBFFC;

  typedef struct packed {
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic        mtip;
    logic        ready;
    logic [31:0] rdata;
  } clint_reg_type;

  localparam clint_reg_type init_clint_reg = '{
    mtime:    64'h0,
    mtimecmp: 64'hFFFF_FFFF_FFFF_FFFF,
    msip:     1'b0,
    mtip:     1'b0,
    ready:    1'b0,
    rdata:    32'h0
  };

  // Replace only the bytes selected by strb.
  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_tick.sv
// RTC divider: pulses tick for one cycle every RTC_DIV core cycles.
// Only instantiated when CLINT_RTC_DIV_EN is defined.
module clint_tick #(
  parameter int RTC_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (RTC_DIV > 2) ? $clog2(RTC_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(RTC_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a one-cycle bus port.
// Define CLINT_RTC_DIV_EN to advance mtime once per RTC_DIV cycles instead of every cycle.
module clint
  import clint_pkg::*;
#(
  parameter int RTC_DIV = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mtip,
  output logic        msip,
  output logic [63:0] mtime
);

  clint_reg_type r, rin;
  logic          tick;
  logic [15:0]   addr;
  logic          wr, rd;

`ifdef CLINT_RTC_DIV_EN
  clint_tick #(.RTC_DIV(RTC_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );
  logic unused_addr;
  assign unused_addr = ^{1'b0, mem_addr[31:16]};
`else
  assign tick = 1'b1;
  logic unused_cfg;
  assign unused_cfg = ^{1'b0, mem_addr[31:16], RTC_DIV[0]};
`endif

  assign addr = mem_addr[15:0];
  assign wr   = mem_valid && (mem_wstrb != 4'b0000);
  assign rd   = mem_valid && (mem_wstrb == 4'b0000);

  always_comb begin
    rin = r;
    if (tick) rin.mtime = r.mtime + 64'd1;
    rin.mtip  = (r.mtime >= r.mtimecmp);
    rin.ready = mem_valid;
    rin.rdata = 32'h0;

    // Reads sample register state before this cycle's updates.
    if (rd) begin
      case (addr)
        clint_msip:      rin.rdata = {31'h0, r.msip};
        clint_mtimecmp:  rin.rdata = r.mtimecmp[31:0];
        clint_mtimecmph: rin.rdata = r.mtimecmp[63:32];
        clint_mtime:     rin.rdata = r.mtime[31:0];
        clint_mtimeh:    rin.rdata = r.mtime[63:32];
        default:         rin.rdata = 32'h0;
      endcase
    end

    // A write to either mtime half overrides that cycle's increment entirely.
    if (wr) begin
      case (addr)
        clint_msip:      if (mem_wstrb[0]) rin.msip = mem_wdata[0];
        clint_mtimecmp:  rin.mtimecmp[31:0]  = byte_merge(r.mtimecmp[31:0], mem_wdata, mem_wstrb);
        clint_mtimecmph: rin.mtimecmp[63:32] = byte_merge(r.mtimecmp[63:32], mem_wdata, mem_wstrb);
        clint_mtime:     rin.mtime = {r.mtime[63:32], byte_merge(r.mtime[31:0], mem_wdata, mem_wstrb)};
        clint_mtimeh:    rin.mtime = {byte_merge(r.mtime[63:32], mem_wdata, mem_wstrb), r.mtime[31:0]};
        default:         ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r <= init_clint_reg;
    end else begin
      r <= rin;
    end
  end

  assign mem_rdata = r.rdata;
  assign mem_ready = r.ready;
  assign mtip      = r.mtip;
  assign msip      = r.msip;
  assign mtime     = r.mtime;

endmodule
